// File: rtl/vmem_ila_pkg.sv
// vmem_ila_pkg: instruction encoding, decode and counter saturation helper shared by the vmem ILA model.
package vmem_ila_pkg;

    typedef enum logic [1:0] {NOP, READ, WRITE, SWAP} instr_t;

    // The encoding is chosen so that {wen, ren} maps directly onto the enum.
    function automatic instr_t decode(input logic ren, input logic wen);
        return instr_t'({wen, ren});
    endfunction

    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/ila_start_counter.sv
// ila_start_counter: cycles-since-decode counter, re-armed to 1 on fire and saturating at max.
module ila_start_counter
    import vmem_ila_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             fire,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    // Zero means "never decoded" and must not start counting on its own.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (step)
            cnt <= fire ? CNT_W'(1) : (cnt != '0 && cnt != MAX) ? cnt + CNT_W'(1) : cnt;
    end

endmodule

// File: rtl/vmem_array_rw_ila.sv
// vmem_array_rw_ila: instruction-level reference model of a register-file memory with READ/WRITE/SWAP.
module vmem_array_rw_ila
    import vmem_ila_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] probe_addr,
    output logic [DATA_W-1:0] probe_data,
    output logic              decode_read,
    output logic              decode_write,
    output logic              decode_swap,
    output logic              valid,
    output logic [DATA_W-1:0] odata,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_swap,
    output logic [CNT_W-1:0]  retired
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [DATA_W-1:0] mem [DEPTH];
    instr_t ins;
    logic step;

    assign ins          = decode(ren, wen);
    assign decode_read  = ins == READ;
    assign decode_write = ins == WRITE;
    assign decode_swap  = ins == SWAP;
    assign valid        = 1'b1;
    assign step         = start & valid & ~rst;
    assign probe_data   = mem[probe_addr];

    // ren covers READ and SWAP; the read sees the pre-write value on a SWAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata   <= '0;
            retired <= '0;
            if (INIT_ZERO != 0)
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (step) begin
            if (ren) odata <= mem[addr];
            if (wen) mem[addr] <= wdata;
            if (ins != NOP && retired != MAX) retired <= retired + CNT_W'(1);
        end
    end

    ila_start_counter #(.CNT_W(CNT_W)) u_cnt_read (
        .clk(clk), .rst(rst), .step(step), .fire(decode_read), .cnt(cnt_read)
    );

    ila_start_counter #(.CNT_W(CNT_W)) u_cnt_write (
        .clk(clk), .rst(rst), .step(step), .fire(decode_write), .cnt(cnt_write)
    );

    ila_start_counter #(.CNT_W(CNT_W)) u_cnt_swap (
        .clk(clk), .rst(rst), .step(step), .fire(decode_swap), .cnt(cnt_swap)
    );

endmodule

// File: tb/tb_vmem_array_rw_ila.sv
// tb_vmem_array_rw_ila: scoreboard bench for the vmem ILA model, one DUT per INIT_ZERO setting.
module tb_vmem_array_rw_ila;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ren = 1'b0;
    logic wen = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [3:0] probe_addr = '0;

    logic [7:0] probe_data, odata, cnt_read, cnt_write, cnt_swap, retired;
    logic decode_read, decode_write, decode_swap, valid;
    logic [7:0] probe_data1, odata1, cnt_read1, cnt_write1, cnt_swap1, retired1;
    logic decode_read1, decode_write1, decode_swap1, valid1;

    int tests = 0;
    int fails = 0;

    logic [7:0] mdl [16];
    logic [7:0] mdl1 [16];
    logic [7:0] exp_q [$];
    logic [7:0] ecr = 0, ecw = 0, ecs = 0, eret = 0, eod = 0;

    always #5 clk = ~clk;

    vmem_array_rw_ila #(.DATA_W(8), .ADDR_W(4), .CNT_W(8), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .probe_addr(probe_addr), .probe_data(probe_data), .decode_read(decode_read),
        .decode_write(decode_write), .decode_swap(decode_swap), .valid(valid), .odata(odata),
        .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_swap(cnt_swap), .retired(retired)
    );

    vmem_array_rw_ila #(.DATA_W(8), .ADDR_W(4), .CNT_W(8), .INIT_ZERO(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .probe_addr(probe_addr), .probe_data(probe_data1), .decode_read(decode_read1),
        .decode_write(decode_write1), .decode_swap(decode_swap1), .valid(valid1), .odata(odata1),
        .cnt_read(cnt_read1), .cnt_write(cnt_write1), .cnt_swap(cnt_swap1), .retired(retired1)
    );

    function automatic logic [7:0] adv(input logic [7:0] c, input logic fire);
        return fire ? 8'd1 : (c != 8'd0 && c != 8'd255) ? c + 8'd1 : c;
    endfunction

    // Drives one instruction for one edge and pushes the expected read result.
    task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d, input logic s);
        logic [7:0] old;
        ren = r; wen = w; addr = a; wdata = d; start = s; rst = 1'b0;
        if (s) begin
            old = mdl[a];
            if (r) begin exp_q.push_back(old); eod = old; end
            if (w) begin mdl[a] = d; mdl1[a] = d; end
            ecr = adv(ecr, r & ~w);
            ecw = adv(ecw, w & ~r);
            ecs = adv(ecs, r & w);
            if ((r | w) && eret != 8'd255) eret = eret + 8'd1;
        end
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'd0;
        ecr = 0; ecw = 0; ecs = 0; eret = 0; eod = 0;
        exp_q.delete();
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, odata=%h", name, odata);
        end else begin
            e = exp_q.pop_front();
            if (odata !== e) begin
                fails++;
                $display("FAIL %s: odata=%h expected %h", name, odata, e);
            end
        end
    endtask

    task automatic test_decode();
        logic [2:0] exp_dec;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ren = i[0]; wen = i[1];
            exp_dec = (i == 1) ? 3'b100 : (i == 2) ? 3'b010 : (i == 3) ? 3'b001 : 3'b000;
            #1;
            tests++;
            if ({decode_read, decode_write, decode_swap} !== exp_dec) begin
                fails++;
                $display("FAIL decode_%0d: got %b expected %b", i, {decode_read, decode_write, decode_swap}, exp_dec);
            end
        end
        ren = 1'b0; wen = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b0, 1'b1, 4'd2, 8'h33, 1'b1);
        step(1'b1, 1'b1, 4'd9, 8'h77, 1'b1);
        step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
        do_reset();
        tests++;
        if ({odata, cnt_read, cnt_write, cnt_swap, retired} !== 40'd0 || valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: odata=%h cr=%0d cw=%0d cs=%0d ret=%0d valid=%b expected zeros, valid=1",
                     odata, cnt_read, cnt_write, cnt_swap, retired, valid);
        end
        for (int i = 0; i < 16; i++) begin
            probe_addr = 4'(i); #1;
            tests++;
            if (probe_data !== 8'h00) begin
                fails++;
                $display("FAIL reset_probe[%0d]: got %h expected 00", i, probe_data);
            end
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b1);
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
        pop_check("write_read_odata");
        tests++;
        if (odata !== 8'hA5 || cnt_write !== 8'd2 || cnt_read !== 8'd1 || retired !== 8'd2) begin
            fails++;
            $display("FAIL write_read: odata=%h cw=%0d cr=%0d ret=%0d expected A5 2 1 2",
                     odata, cnt_write, cnt_read, retired);
        end
    endtask

    task automatic test_swap();
        step(1'b0, 1'b1, 4'd7, 8'h11, 1'b1);
        step(1'b1, 1'b1, 4'd7, 8'h22, 1'b1);
        pop_check("swap_odata");
        probe_addr = 4'd7; #1;
        tests++;
        if (odata !== 8'h11 || probe_data !== 8'h22 || cnt_swap !== 8'd1) begin
            fails++;
            $display("FAIL swap: odata=%h probe=%h cs=%0d expected 11 22 1", odata, probe_data, cnt_swap);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 4'd9, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 4'd9, 8'h00, 1'b1);
        pop_check("b2b_read1");
        step(1'b1, 1'b0, 4'd9, 8'h00, 1'b1);
        pop_check("b2b_read2");
        tests++;
        if (cnt_read !== 8'd1 || cnt_write !== ecw || retired !== eret) begin
            fails++;
            $display("FAIL b2b_counters: cr=%0d cw=%0d ret=%0d expected 1 %0d %0d", cnt_read, cnt_write, retired, ecw, eret);
        end
        step(1'b1, 1'b1, 4'd9, 8'hC3, 1'b1);
        pop_check("b2b_swap");
        step(1'b1, 1'b0, 4'd9, 8'h00, 1'b1);
        pop_check("b2b_after_swap");
        tests++;
        if (odata !== 8'hC3) begin
            fails++;
            $display("FAIL b2b_swap_then_read: odata=%h expected C3", odata);
        end
    endtask

    task automatic test_saturation();
        int bad;
        logic [7:0] e;
        do_reset();
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
        pop_check("sat_read");
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
            e = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
            tests++;
            if (cnt_read !== e) begin
                fails++;
                $display("FAIL sat_cnt_read step %0d: got %0d expected %0d", k, cnt_read, e);
            end
        end
        tests++;
        if (retired !== 8'd1 || cnt_write !== 8'd0 || cnt_swap !== 8'd0) begin
            fails++;
            $display("FAIL sat_other: ret=%0d cw=%0d cs=%0d expected 1 0 0", retired, cnt_write, cnt_swap);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 4'd3, 8'h5A, 1'b1);
        ren = 1'b1; wen = 1'b0; addr = 4'd3; start = 1'b0; probe_addr = 4'd3;
        #1;
        tests++;
        if (decode_read !== 1'b1) begin
            fails++;
            $display("FAIL hold_decode: decode_read=%b expected 1", decode_read);
        end
        @(posedge clk); #1;
        ren = 1'b0;
        tests++;
        if (odata !== eod || cnt_read !== ecr || cnt_write !== ecw || cnt_swap !== ecs ||
            retired !== eret || probe_data !== 8'h5A) begin
            fails++;
            $display("FAIL hold_state: odata=%h cr=%0d cw=%0d cs=%0d ret=%0d probe=%h expected %h %0d %0d %0d %0d 5A",
                     odata, cnt_read, cnt_write, cnt_swap, retired, probe_data, eod, ecr, ecw, ecs, eret);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 4'd5, 8'h40, 1'b1);
        pop_check("mid_swap");
        rst = 1'b1; start = 1'b1; ren = 1'b0; wen = 1'b1; addr = 4'd5; wdata = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; wen = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'd0;
        probe_addr = 4'd5; #1;
        tests++;
        if (probe_data1 !== mdl1[5] || probe_data1 !== 8'h40) begin
            fails++;
            $display("FAIL mid_keep: probe1=%h expected 40", probe_data1);
        end
        tests++;
        if ({odata1, cnt_read1, cnt_write1, cnt_swap1, retired1} !== 40'd0) begin
            fails++;
            $display("FAIL mid_reset1: odata=%h cr=%0d cw=%0d cs=%0d ret=%0d expected zeros",
                     odata1, cnt_read1, cnt_write1, cnt_swap1, retired1);
        end
        tests++;
        if (probe_data !== 8'h00 || odata !== 8'h00 || retired !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset0: probe=%h odata=%h ret=%0d expected 00 00 0", probe_data, odata, retired);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mdl[i] = 8'd0; mdl1[i] = 8'd0; end
        test_decode();
        test_reset();
        test_write_read();
        test_swap();
        test_back_to_back();
        test_saturation();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vmem_array_rw_ila.md
Name: vmem_array_rw_ila

Overview:
- Parametrised instruction-level (ILA) reference model of a register-file style memory.
- Decodes three instructions (READ, WRITE, SWAP) from per-cycle control inputs.
- Updates the architectural state (memory array, odata) and keeps per-instruction "cycles-since-decode" start counters.
- Sits alongside the RTL implementation in the vmem refinement flow; equivalence and forall-address properties are checked against it through a combinational probe port.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 4, address width; depth = 2**ADDR_W
- CNT_W, 8, width of each start counter; saturation value = 2**CNT_W-1
- INIT_ZERO, 1, 1: all array entries clear to 0 on reset; 0: array holds its contents across reset

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  model step enable; state updates only when start=1
- ren  in  1  read request
- wen  in  1  write request
- addr  in  ADDR_W  instruction address
- wdata  in  DATA_W  write data
- probe_addr  in  ADDR_W  verification probe address
- probe_data  out  DATA_W  combinational array[probe_addr]
- decode_read  out  1  READ instruction decoded (combinational)
- decode_write  out  1  WRITE instruction decoded (combinational)
- decode_swap  out  1  SWAP instruction decoded (combinational)
- valid  out  1  model valid flag
- odata  out  DATA_W  architectural read result (registered)
- cnt_read  out  CNT_W  start counter for READ
- cnt_write  out  CNT_W  start counter for WRITE
- cnt_swap  out  CNT_W  start counter for SWAP
- retired  out  CNT_W  saturating count of decoded instructions

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: odata=0, all cnt_*=0, retired=0. If INIT_ZERO=1, every array entry is 0; if INIT_ZERO=0, the array is untouched.
- valid is constant 1.
- Decode, combinational and one-hot or all-zero:
  - READ = ren & ~wen
  - WRITE = wen & ~ren
  - SWAP = ren & wen
  - ren=wen=0 is a NOP: no decode asserted, no state change other than counter advance.
- Decode outputs reflect the inputs regardless of start and rst.
- Step condition: ~rst & start & valid. With no step, all state holds; counters also hold.
- READ on step: odata <= array[addr]; array unchanged.
- WRITE on step: array[addr] <= wdata; odata holds.
- SWAP on step: odata <= old array[addr], i.e. the pre-write value, never wdata; array[addr] <= wdata in the same edge.
- Latency: odata and array updates are visible 1 cycle after the stepping edge. probe_data is combinational off the current array, so it shows a write on the cycle after the edge.
- Start counter rule, per instruction X, on step:
  - if decode_X: cnt_X <= 1
  - else if 1 <= cnt_X < 2**CNT_W-1: cnt_X <= cnt_X+1
  - else cnt_X holds; 0 stays 0 until first decode, and the counter saturates at max.
- retired: +1 on every step with any decode asserted; saturates at 2**CNT_W-1; NOP does not count.
- Back-to-back: a WRITE then a READ of the same addr on consecutive steps returns the new data. A repeated decode of X re-arms cnt_X to 1.
- Reset mid-operation: rst dominates start. The in-flight instruction is discarded, the array is not written, and the reset values apply on that edge.
- Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.

Decomposition:
- Package vmem_ila_pkg holds:
  - instruction enum {NOP, READ, WRITE, SWAP}
  - function decode(ren, wen) returning the enum
  - localparam helper for counter saturation value
- One sub-module, ila_start_counter (params CNT_W; inputs clk, rst, step, fire; output cnt), instantiated three times.
- retired is a plain saturating counter in the top module.

Test Plan:
- Reset, INIT_ZERO=1, DATA_W=8, ADDR_W=4, after prior writes -> odata=0, cnt_*=0, retired=0, probe_data=0 for all 16 addresses.
- start=1: WRITE addr=3 wdata=0xA5, then READ addr=3 -> after 2nd edge odata=0xA5, cnt_write=2, cnt_read=1, retired=2.
- array[7]=0x11, SWAP addr=7 wdata=0x22 -> odata=0x11, probe_data(7)=0x22, cnt_swap=1.
- READ once, then 300 NOP steps with CNT_W=8 -> cnt_read climbs 1..255 and holds at 255; retired stays 1.
- start=0 with ren=1 addr=3 -> decode_read=1, but odata, array and counters unchanged.
- rst=1 in the same cycle as WRITE addr=5 wdata=0xFF, with INIT_ZERO=0 and array[5]=0x40 -> array[5] stays 0x40, counters and odata reset to 0.
